hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Drives the decode-stage branch-compare operand muxes (ForwardAD/ForwardBD), the execute-stage ALU operand muxes (ForwardAE/ForwardBE), and the StallF, StallD and FlushE controls.
- Also sequences the multi-cycle MULT/DIV unit: it tracks the unit's busy window with an internal down-counter and stalls dependent instructions in decode.

---
 rtl/hazard_if.sv | 32 +++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: bundles every pipeline-facing signal of the hazard controller.
//   master : pipeline side (drives register ids, enables and opcode flags,
//            receives forwarding selects and stall/flush controls)
//   slave  : hazard_ctrl side
// Signal names match the classic Harris & Harris MIPS datapath labels.
interface hazard_if;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM;
  logic       BranchD, JumpRegD, MdOpD, HiLoReadD;
  logic       MdStartE, MdDivE;
  logic [1:0] ForwardAD, ForwardBD, ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushE;
  logic       MdBusy, MdErr;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JumpRegD, MdOpD, HiLoReadD, MdStartE, MdDivE,
    input  ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           StallF, StallD, FlushE, MdBusy, MdErr
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JumpRegD, MdOpD, HiLoReadD, MdStartE, MdDivE,
    output ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           StallF, StallD, FlushE, MdBusy, MdErr
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and forwarding control for a 5-stage MIPS
// pipeline, plus busy-window tracking of the multi-cycle MULT/DIV unit.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : hazard_if.slave
//     in  : Rs/Rt (D,E), WriteReg (E,M,W), RegWrite (E,M,W), MemtoReg (E,M),
//           BranchD, JumpRegD, MdOpD, HiLoReadD, MdStartE, MdDivE
//     out : ForwardAD/BD (00 rf, 01 ALUOutM, 10 execute result),
//           ForwardAE/BE (00 rf, 01 ResultW, 10 ALUOutM),
//           StallF, StallD, FlushE, MdBusy, MdErr (sticky)
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             md_err_q;
  logic             md_busy;
  logic             lwstall, brstall, mdstall, stall;
  logic [1:0]       fwd_ad, fwd_bd, fwd_ae, fwd_be;

  // Decode-stage select: execute-stage ALU result wins over memory stage.
  // Loads are excluded because their data does not exist yet (they stall).
  function automatic logic [1:0] dec_sel(input logic [4:0] src,
                                         input logic [4:0] wr_e, input logic we_e, input logic ld_e,
                                         input logic [4:0] wr_m, input logic we_m, input logic ld_m);
    dec_sel = 2'b00;
    if (src != 5'd0) begin
      if (src == wr_e && we_e && !ld_e)      dec_sel = 2'b10;
      else if (src == wr_m && we_m && !ld_m) dec_sel = 2'b01;
    end
  endfunction

  function automatic logic [1:0] exe_sel(input logic [4:0] src,
                                         input logic [4:0] wr_m, input logic we_m,
                                         input logic [4:0] wr_w, input logic we_w);
    exe_sel = 2'b00;
    if (src != 5'd0) begin
      if (src == wr_m && we_m)      exe_sel = 2'b10;
      else if (src == wr_w && we_w) exe_sel = 2'b01;
    end
  endfunction

  // Busy counter: a start is accepted only while idle; a start while busy
  // is ignored and latches the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      md_err_q <= 1'b0;
    end else begin
      if (bus.MdStartE && cnt == '0) begin
        cnt <= bus.MdDivE ? DIV_LOAD : MULT_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
      if (bus.MdStartE && cnt != '0) begin
        md_err_q <= 1'b1;
      end
    end
  end

  assign md_busy = (cnt != '0);

  always_comb begin
    fwd_ad  = dec_sel(bus.RsD, bus.WriteRegE, bus.RegWriteE, bus.MemtoRegE,
                      bus.WriteRegM, bus.RegWriteM, bus.MemtoRegM);
    fwd_bd  = dec_sel(bus.RtD, bus.WriteRegE, bus.RegWriteE, bus.MemtoRegE,
                      bus.WriteRegM, bus.RegWriteM, bus.MemtoRegM);
    fwd_ae  = exe_sel(bus.RsE, bus.WriteRegM, bus.RegWriteM, bus.WriteRegW, bus.RegWriteW);
    fwd_be  = exe_sel(bus.RtE, bus.WriteRegM, bus.RegWriteM, bus.WriteRegW, bus.RegWriteW);

    lwstall = bus.MemtoRegE && bus.RegWriteE &&
              ((bus.RsD != 5'd0 && bus.WriteRegE == bus.RsD) ||
               (bus.RtD != 5'd0 && bus.WriteRegE == bus.RtD));
    // JR/JALR only reads Rs; BEQ/BNE compares both operands.
    brstall = (bus.BranchD || bus.JumpRegD) && bus.MemtoRegM && bus.RegWriteM &&
              ((bus.RsD != 5'd0 && bus.WriteRegM == bus.RsD) ||
               (bus.BranchD && bus.RtD != 5'd0 && bus.WriteRegM == bus.RtD));
    mdstall = md_busy && (bus.MdOpD || bus.HiLoReadD);
    stall   = lwstall || brstall || mdstall;

    bus.ForwardAD = fwd_ad;
    bus.ForwardBD = fwd_bd;
    bus.ForwardAE = fwd_ae;
    bus.ForwardBE = fwd_be;
    bus.StallF    = stall;
    bus.StallD    = stall;
    bus.FlushE    = stall;
    bus.MdBusy    = md_busy;
    bus.MdErr     = md_err_q;

    // While reset is asserted the pipeline sees a held bubble, no forwarding.
    if (!rst_n) begin
      bus.ForwardAD = 2'b00;
      bus.ForwardBD = 2'b00;
      bus.ForwardAE = 2'b00;
      bus.ForwardBE = 2'b00;
      bus.StallF    = 1'b0;
      bus.StallD    = 1'b0;
      bus.FlushE    = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_if bus ();

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Model of the HI/LO unit as an absolute edge number at which it frees up.
  int  ec     = 0;
  int  md_end = 0;
  bit  m_err  = 1'b0;

  function automatic bit m_busy();
    return ec < md_end;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.MdStartE) begin
        if (m_busy()) m_err = 1'b1;
        else          md_end = ec + 1 + ((bus.MdDivE ? DIV_N : MULT_N) - 1);
      end
    end
    ec = ec + 1;
  end

  always @(negedge rst_n) begin
    md_end = ec;
    m_err  = 1'b0;
  end

  function automatic logic [1:0] m_dec(input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (r == bus.WriteRegE && bus.RegWriteE && !bus.MemtoRegE) return 2'b10;
    if (r == bus.WriteRegM && bus.RegWriteM && !bus.MemtoRegM) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] m_exe(input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (r == bus.WriteRegM && bus.RegWriteM) return 2'b10;
    if (r == bus.WriteRegW && bus.RegWriteW) return 2'b01;
    return 2'b00;
  endfunction

  // Packing: {AD, BD, AE, BE, StallF, StallD, FlushE, MdBusy, MdErr}
  function automatic logic [12:0] m_expect();
    bit ld_use, br_dep, md_dep, st;
    if (!rst_n) return {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ld_use = bus.MemtoRegE && bus.RegWriteE &&
             ((bus.RsD != 0 && bus.RsD == bus.WriteRegE) || (bus.RtD != 0 && bus.RtD == bus.WriteRegE));
    br_dep = bus.MemtoRegM && bus.RegWriteM &&
             ((bus.JumpRegD && bus.RsD != 0 && bus.RsD == bus.WriteRegM) ||
              (bus.BranchD && ((bus.RsD != 0 && bus.RsD == bus.WriteRegM) ||
                               (bus.RtD != 0 && bus.RtD == bus.WriteRegM))));
    md_dep = m_busy() && (bus.MdOpD || bus.HiLoReadD);
    st = ld_use || br_dep || md_dep;
    return {m_dec(bus.RsD), m_dec(bus.RtD), m_exe(bus.RsE), m_exe(bus.RtE),
            st, st, st, m_busy(), m_err};
  endfunction

  function automatic logic [12:0] dut_out();
    return {bus.ForwardAD, bus.ForwardBD, bus.ForwardAE, bus.ForwardBE,
            bus.StallF, bus.StallD, bus.FlushE, bus.MdBusy, bus.MdErr};
  endfunction

  // Scoreboard: every cycle the model's expected outputs are queued and
  // checked against the DUT at the falling edge.
  logic [12:0] exp_q[$];
  always @(negedge clk) begin
    logic [12:0] e, a;
    exp_q.push_back(m_expect());
    e = exp_q.pop_front();
    a = dut_out();
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL cycle_model t=%0t: got %b, expected %b", $time, a, e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clr();
    bus.RsD = 0; bus.RtD = 0; bus.RsE = 0; bus.RtE = 0;
    bus.WriteRegE = 0; bus.WriteRegM = 0; bus.WriteRegW = 0;
    bus.RegWriteE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
    bus.MemtoRegE = 0; bus.MemtoRegM = 0;
    bus.BranchD = 0; bus.JumpRegD = 0; bus.MdOpD = 0; bus.HiLoReadD = 0;
    bus.MdStartE = 0; bus.MdDivE = 0;
  endtask

  initial begin
    int nb;
    clr();
    // Reset forces outputs regardless of hazards on the inputs.
    bus.RsD = 3; bus.WriteRegE = 3; bus.RegWriteE = 1; bus.RsE = 7;
    bus.WriteRegM = 7; bus.RegWriteM = 1;
    settle();
    check("rst_fwd_ad", bus.ForwardAD, 0);
    check("rst_fwd_ae", bus.ForwardAE, 0);
    check("rst_flush", bus.FlushE, 1);
    check("rst_stall", bus.StallF, 0);
    check("rst_busy", bus.MdBusy, 0);
    tick(); tick();
    rst_n = 1'b1;
    clr();

    // ADD $3 in E, BEQ reads $3 in D
    bus.WriteRegE = 3; bus.RegWriteE = 1; bus.BranchD = 1; bus.RsD = 3;
    settle(); check("add_e_fwd_ad", bus.ForwardAD, 2); check("add_e_stall", bus.StallD, 0);
    tick(); clr();
    // ADD moved to M, BEQ reads $3 on Rt
    bus.WriteRegM = 3; bus.RegWriteM = 1; bus.BranchD = 1; bus.RtD = 3;
    settle(); check("add_m_fwd_bd", bus.ForwardBD, 1); check("add_m_stall", bus.StallF, 0);
    tick(); clr();

    // LW $5 in E, ADD uses $5 in D: one bubble
    bus.WriteRegE = 5; bus.RegWriteE = 1; bus.MemtoRegE = 1; bus.RtD = 5;
    settle(); check("lw_use_stall", bus.StallF, 1); check("lw_use_flush", bus.FlushE, 1);
    check("lw_no_dec_fwd", bus.ForwardBD, 0);
    tick(); clr();
    // LW in M, BEQ on $5
    bus.WriteRegM = 5; bus.RegWriteM = 1; bus.MemtoRegM = 1; bus.BranchD = 1; bus.RsD = 5;
    settle(); check("br_lw_m_stall", bus.StallD, 1);
    tick(); clr();
    // LW in W: no more stall
    bus.WriteRegW = 5; bus.RegWriteW = 1; bus.BranchD = 1; bus.RsD = 5;
    settle(); check("br_lw_w_stall", bus.StallD, 0); check("br_lw_w_fwd", bus.ForwardAD, 0);
    tick(); clr();

    // JR only looks at Rs; a load to its Rt register is harmless
    bus.WriteRegM = 6; bus.RegWriteM = 1; bus.MemtoRegM = 1; bus.JumpRegD = 1;
    bus.RsD = 1; bus.RtD = 6;
    settle(); check("jr_rt_nostall", bus.StallF, 0);
    tick();
    bus.JumpRegD = 0; bus.BranchD = 1;
    settle(); check("beq_rt_stall", bus.StallF, 1);
    tick(); clr();

    // Execute forwarding: M priority over W
    bus.WriteRegM = 7; bus.WriteRegW = 7; bus.RegWriteM = 1; bus.RegWriteW = 1;
    bus.RsE = 7; bus.RtE = 7;
    settle(); check("exe_m_prio", bus.ForwardAE, 2);
    tick();
    bus.RegWriteM = 0;
    settle(); check("exe_w_fwd", bus.ForwardBE, 1);
    tick(); clr();
    bus.RsE = 0; bus.WriteRegM = 0; bus.RegWriteM = 1; bus.WriteRegW = 0; bus.RegWriteW = 1;
    settle(); check("exe_r0", bus.ForwardAE, 0);
    tick(); clr();

    // MULT then dependent MFLO: three stall cycles, then released
    bus.MdStartE = 1; bus.MdDivE = 0;
    tick();
    bus.MdStartE = 0; bus.HiLoReadD = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        // overlap a load-use hazard with the HI/LO stall: still a single stall
        bus.WriteRegE = 9; bus.RegWriteE = 1; bus.MemtoRegE = 1; bus.RsD = 9;
      end else begin
        bus.WriteRegE = 0; bus.RegWriteE = 0; bus.MemtoRegE = 0; bus.RsD = 0;
      end
      settle();
      check($sformatf("mflo_stall_%0d", i), bus.StallD, (i < 3) ? 1 : 0);
      tick();
    end
    clr();

    // DIV with an illegal start pulsed mid-window
    bus.MdStartE = 1; bus.MdDivE = 1;
    tick();
    bus.MdStartE = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (!bus.MdBusy) break;
      nb++;
      bus.MdStartE = (i == 4);
      tick();
    end
    bus.MdStartE = 0;
    check("div_busy_len", nb, DIV_N - 1);
    check("md_err_set", bus.MdErr, 1);
    tick(); tick();
    check("md_err_sticky", bus.MdErr, 1);

    // Reset in the middle of a DIV (counter at 20)
    bus.MdStartE = 1;
    tick();
    bus.MdStartE = 0;
    repeat (11) tick();
    bus.HiLoReadD = 1; bus.RsD = 3; bus.WriteRegE = 3; bus.RegWriteE = 1;
    #1;
    check("pre_rst_stall", bus.StallD, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.MdBusy, 0);
    check("mid_rst_flush", bus.FlushE, 1);
    check("mid_rst_fwd", bus.ForwardAD, 0);
    check("mid_rst_err", bus.MdErr, 0);
    settle();
    tick();
    rst_n = 1'b1;
    settle();
    check("post_rst_mfhi", bus.StallD, 0);
    check("post_rst_busy", bus.MdBusy, 0);
    tick();
    clr();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
